instr_fetch: RTL

- Instruction fetch stage that sits directly upstream of the decoder and drives the code read port of the unified memory.
- Holds the fetch PC, presents it on code_addr, and captures the combinationally returned r_code word into a small prefetch FIFO.
- Hands {pc, instr} pairs to the decoder over a valid/ready handshake.
- Handles branch redirect/flush, fetch gating, and fault detection for misaligned or out-of-ROM fetch addresses.

---
 rtl/instr_fetch.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch stage between the unified memory code port and the
// decoder. It holds the fetch PC and drives it out on code_addr. The memory
// returns the matching word on r_code in the same cycle. That word is
// captured with its PC into a small prefetch FIFO, and the FIFO head is
// offered to the decoder over a valid/ready handshake.
//
// Branch redirects flush the FIFO and reload the PC. A fetch from a
// misaligned or out-of-ROM address stops fetching and raises a sticky fault.
// Only a branch or a reset clears that fault.
//
// Ports:
//   clk            system clock, all state updates on the rising edge
//   rst            synchronous active-low reset
//   fetch_en       1 = new fetches allowed; 0 = hold PC, FIFO still drains
//   code_addr      byte address to the memory code port (the fetch PC)
//   r_code         instruction word for code_addr, same cycle
//   instr_valid    FIFO head is valid
//   instr_ready    decoder takes the head this cycle
//   instr          instruction word at the FIFO head
//   instr_pc       address of the instruction at the FIFO head
//   branch_en      redirect request (flush + reload PC)
//   branch_target  new fetch address
//   fault          sticky fetch fault flag
// ---------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0004,
  parameter logic [31:0] ROM_LIMIT = 32'h0001_ffff,
  parameter int          DEPTH     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  output logic [31:0] code_addr,
  input  logic [31:0] r_code,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        branch_en,
  input  logic [31:0] branch_target,
  output logic        fault
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  typedef enum logic {
    RUN,
    FAULT
  } state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [31:0]   hold_instr;
  logic [31:0]   hold_pc;

  logic addr_ok;
  logic push;
  logic pop;

  // The last fetchable word starts at ROM_LIMIT-3, so any word address past
  // that would read beyond the ROM.
  assign addr_ok = (fetch_pc[1:0] == 2'b00) && (fetch_pc <= (ROM_LIMIT - 32'd3));

  assign instr_valid = (count != '0);
  assign code_addr   = fetch_pc;

  // A branch voids any decoder handshake in the same cycle. A full FIFO
  // still accepts a push when the head is leaving at the same edge.
  assign pop  = instr_valid && instr_ready && !branch_en;
  assign push = (state == RUN) && fetch_en && !branch_en &&
                ((count < DEPTH_C) || pop) && addr_ok;

  // When the FIFO is empty, the head outputs show the last value that was
  // presented, or zero if nothing has been presented since reset.
  assign instr    = instr_valid ? instr_mem[rd_ptr] : hold_instr;
  assign instr_pc = instr_valid ? pc_mem[rd_ptr]    : hold_pc;

  // FIFO storage. It needs no reset because the head is only read while
  // count is non-zero.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      pc_mem[wr_ptr]    <= fetch_pc;
      instr_mem[wr_ptr] <= r_code;
    end
  end

  // Control: PC, pointers, occupancy, state and fault flag. Reset comes
  // first, then branch, then normal push/pop and fault detection.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc   <= RESET_PC;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      state      <= RUN;
      fault      <= 1'b0;
      hold_instr <= '0;
      hold_pc    <= '0;
    end else begin
      if (instr_valid) begin
        hold_instr <= instr_mem[rd_ptr];
        hold_pc    <= pc_mem[rd_ptr];
      end
      if (branch_en) begin
        fetch_pc <= branch_target;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        state    <= RUN;
        fault    <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr   <= wr_ptr + AW'(1);
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        if (push && !pop) begin
          count <= count + (AW + 1)'(1);
        end else if (pop && !push) begin
          count <= count - (AW + 1)'(1);
        end
        // A bad address stops fetching and leaves fetch_pc on the faulting
        // address. Entries already queued keep draining.
        if (state == RUN && fetch_en && !addr_ok) begin
          state <= FAULT;
          fault <= 1'b1;
        end
      end
    end
  end

endmodule
